down_counter_32: RTL and testbench

- Programmable down-counting timer; the load/terminal-count counterpart of the free-running 32-bit up counter.
- A master loads a start value through a valid/ready handshake. The block counts down to zero and flags terminal count (tc).
- Runs one-shot or periodic (auto-reload).
- Used as a timeout/interval source beside the up counter in the same clock domain.

---
 rtl/down_counter_pkg.sv | 14 +
 rtl/down_counter_if.sv | 27 ++
 rtl/down_counter_prescaler.sv | 39 +++
 rtl/down_counter_32.sv | 125 ++++++++++++
 tb/tb_down_counter_32.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/down_counter_pkg.sv
// rtl/down_counter_pkg.sv - shared types and constants for the down counter
package down_counter_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/down_counter_if.sv
// rtl/down_counter_if.sv - load channel (valid/ready, value, mode) of the down counter
interface down_counter_if
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;
    logic             load_mode;

    modport master (
        output load_valid,
        output load_value,
        output load_mode,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_value,
        input  load_mode,
        output load_ready
    );

endinterface

// File: rtl/down_counter_prescaler.sv
// rtl/down_counter_prescaler.sv - step strobe every PRESCALE enabled cycles (used with DOWN_COUNTER_PRESCALE_EN)
module down_counter_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic step
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign step = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (step) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/down_counter_32.sv
// rtl/down_counter_32.sv - loadable one-shot/periodic down-counting timer; DOWN_COUNTER_PRESCALE_EN adds a prescaler
module down_counter_32
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
`ifdef DOWN_COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    down_counter_if.slave    lif,
    input  logic             enable,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             tc_q, tc_d;
    logic             load_ready_q, load_ready_d;

    logic xfer;
    logic step;

    assign xfer = lif.load_valid && load_ready_q;

`ifdef DOWN_COUNTER_PRESCALE_EN
    down_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (xfer || stop),
        .enable (enable && (state_q == RUN)),
        .step   (step)
    );
`else
    assign step = enable;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            reload_q     <= '0;
            mode_q       <= MODE_ONESHOT;
            tc_q         <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            reload_q     <= reload_d;
            mode_q       <= mode_d;
            tc_q         <= tc_d;
            load_ready_q <= load_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (xfer && (lif.load_value != '0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (step && (count_q == ONE) && (mode_q == MODE_ONESHOT)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A zero load is a degenerate run: it only pulses tc and never enters RUN.
    always_comb begin
        count_d      = count_q;
        reload_d     = reload_q;
        mode_d       = mode_q;
        tc_d         = 1'b0;
        load_ready_d = (state_d == IDLE);
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    count_d  = lif.load_value;
                    reload_d = lif.load_value;
                    mode_d   = lif.load_mode;
                    tc_d     = (lif.load_value == '0);
                end
            end
            RUN: begin
                if (stop) begin
                    count_d = '0;
                end else if (step) begin
                    if (count_q == '0) begin
                        count_d = reload_q;
                    end else if (count_q == ONE) begin
                        count_d = '0;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_q - ONE;
                    end
                end
            end
            default: ;
        endcase
    end

    assign lif.load_ready = load_ready_q;
    assign count          = count_q;
    assign tc             = tc_q;
    assign busy           = (state_q == RUN);

endmodule

// File: tb/tb_down_counter_32.sv
// tb/tb_down_counter_32.sv - directed scoreboard bench for down_counter_32
module tb_down_counter_32;
    import down_counter_pkg::*;

`ifdef DOWN_COUNTER_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        enable = 1'b0;
    logic        stop   = 1'b0;
    logic [31:0] count;
    logic        tc;
    logic        busy;

    down_counter_if #(.WIDTH(32)) lif ();

    down_counter_32 dut (
        .clk    (clk),
        .reset  (reset),
        .lif    (lif.slave),
        .enable (enable),
        .stop   (stop),
        .count  (count),
        .tc     (tc),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] count;
        logic        tc;
        logic        busy;
        logic        ready;
    } obs_t;

    obs_t sb[$];

    int n_cmp   = 0;
    int n_err   = 0;
    int tc_seen = 0;
    int cyc_no  = 0;

    logic        m_run    = 1'b0;
    logic [31:0] m_count  = '0;
    logic [31:0] m_reload = '0;
    logic        m_mode   = 1'b0;
    int          m_pre    = 0;

    // One clock: drive inputs, predict with the reference model, then check after the edge.
    task automatic cyc(input logic rst, input logic lv, input logic [31:0] val,
                       input logic lm, input logic en, input logic st);
        obs_t e;
        obs_t o;
        logic stp;
        reset          = rst;
        lif.load_valid = lv;
        lif.load_value = val;
        lif.load_mode  = lm;
        enable         = en;
        stop           = st;
        e.tc = 1'b0;
        if (!rst) begin
            m_run = 1'b0; m_count = '0; m_reload = '0; m_mode = 1'b0; m_pre = 0;
        end else if (!m_run) begin
            if (lv) begin
                m_count = val; m_reload = val; m_mode = lm; m_pre = 0;
                if (val == 32'd0) e.tc = 1'b1;
                else m_run = 1'b1;
            end
        end else if (st) begin
            m_count = '0; m_run = 1'b0; m_pre = 0;
        end else if (en) begin
            stp   = (m_pre == PS - 1);
            m_pre = stp ? 0 : m_pre + 1;
            if (stp) begin
                if (m_count == 32'd0) begin
                    m_count = m_reload;
                end else if (m_count == 32'd1) begin
                    m_count = '0;
                    e.tc    = 1'b1;
                    if (m_mode == MODE_ONESHOT) m_run = 1'b0;
                end else begin
                    m_count = m_count - 32'd1;
                end
            end
        end
        e.count = m_count;
        e.busy  = m_run;
        e.ready = !m_run;
        sb.push_back(e);

        @(posedge clk);
        #1;
        cyc_no++;
        o = {count, tc, busy, lif.load_ready};
        if (tc === 1'b1) tc_seen++;
        e = sb.pop_front();
        n_cmp++;
        assert (o === e)
        else begin
            n_err++;
            $error("FAIL cyc%0d count/tc/busy/ready observed %h/%b/%b/%b expected %h/%b/%b/%b",
                   cyc_no, o.count, o.tc, o.busy, o.ready, e.count, e.tc, e.busy, e.ready);
        end
    endtask

    task automatic check_tc(input int exp, input string tag);
        n_cmp++;
        assert (tc_seen === exp)
        else begin
            n_err++;
            $error("FAIL tc_count_%s observed %0d expected %0d", tag, tc_seen, exp);
        end
        tc_seen = 0;
    endtask

    task automatic run(input int n, input logic en);
        repeat (n) cyc(1'b1, 1'b0, 32'd0, 1'b0, en, 1'b0);
    endtask

    logic [15:0] pat;

    initial begin
        lif.load_valid = 1'b0;
        lif.load_value = '0;
        lif.load_mode  = 1'b0;

        repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        // reset in the middle of a run
        cyc(1'b1, 1'b1, 32'd7, MODE_ONESHOT, 1'b0, 1'b0);
        run(1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        run(1, 1'b0);
        check_tc(0, "reset");

        // one-shot
        cyc(1'b1, 1'b1, 32'd5, MODE_ONESHOT, 1'b1, 1'b0);
        run(8 * PS, 1'b1);
        check_tc(1, "oneshot");

        // periodic
        cyc(1'b1, 1'b1, 32'd3, MODE_PERIODIC, 1'b1, 1'b0);
        run(12 * PS - 1, 1'b1);
        check_tc(3, "periodic");
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        check_tc(0, "periodic_stop");

        // enable gating
        pat = 16'b1011_0110_1001_1001;
        cyc(1'b1, 1'b1, 32'd4, MODE_ONESHOT, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) run(PS, pat[i]);
        check_tc(1, "gating");

        // stop at count 1 together with enable
        cyc(1'b1, 1'b1, 32'd2, MODE_ONESHOT, 1'b1, 1'b0);
        run(PS, 1'b1);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        run(2, 1'b1);
        check_tc(0, "stop");

        // zero loads in both modes
        cyc(1'b1, 1'b1, 32'd0, MODE_ONESHOT, 1'b1, 1'b0);
        run(1, 1'b1);
        cyc(1'b1, 1'b1, 32'd0, MODE_PERIODIC, 1'b1, 1'b0);
        run(3, 1'b1);
        check_tc(2, "zero_load");

        // load held during a run, accepted on the first ready cycle
        cyc(1'b1, 1'b1, 32'd3, MODE_ONESHOT, 1'b1, 1'b0);
        repeat (4 * PS + 3) cyc(1'b1, 1'b1, 32'd9, MODE_PERIODIC, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check_tc(1, "handshake");

        // maximum start value
        cyc(1'b1, 1'b1, 32'hFFFF_FFFF, MODE_ONESHOT, 1'b1, 1'b0);
        run(3 * PS, 1'b1);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        run(1, 1'b0);
        check_tc(0, "max_value");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
